// File: rtl/ifu_prefetch_if.sv
// Fetch-path bundle between the prefetch unit, instruction memory and core.
// master is the prefetch unit; slave is the memory/core side.
interface ifu_prefetch_if;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        inst_valid;
    logic [31:0] inst_pc;
    logic [31:0] inst;
    logic        inst_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output mem_req_valid, mem_req_addr,
        input  mem_req_ready, mem_resp_valid, mem_resp_data,
        output inst_valid, inst_pc, inst,
        input  inst_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  mem_req_valid, mem_req_addr,
        output mem_req_ready, mem_resp_valid, mem_resp_data,
        input  inst_valid, inst_pc, inst,
        output inst_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/ifu_prefetch.sv
// Credit-based instruction prefetcher: in-order request/response fetch into a
// DEPTH-entry {pc, word} FIFO, with redirect flush and stale-response discard.
module ifu_prefetch #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic           clk,
    input  logic           rst,
    ifu_prefetch_if.master bus
);
    localparam int unsigned PW      = $clog2(DEPTH);
    localparam int unsigned CW      = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic          started;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] stale;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] tag_wr;
    logic [PW-1:0] tag_rd;
    logic [31:0]   fifo_pc   [DEPTH];
    logic [31:0]   fifo_word [DEPTH];
    logic [31:0]   tag_pc    [DEPTH];

    logic          req_valid;
    logic          head_valid;
    logic          req_fire;
    logic          resp_take;
    logic          resp_drop;
    logic          push;
    logic          pop;
    logic [CW-1:0] out_next;

    // Credit covers both buffered and in-flight words, so every live response has room.
    assign req_valid  = started && (({1'b0, count} + {1'b0, outstanding}) < DEPTH_W);
    assign head_valid = (count != '0);

    assign req_fire  = req_valid && bus.mem_req_ready;
    assign resp_take = bus.mem_resp_valid && (outstanding != '0);
    assign resp_drop = resp_take && (stale != '0);
    assign push      = resp_take && !resp_drop && !bus.redirect_valid;
    assign pop       = head_valid && bus.inst_ready;
    assign out_next  = outstanding + CW'(req_fire) - CW'(resp_take);

    assign bus.mem_req_valid = req_valid;
    assign bus.mem_req_addr  = fetch_pc;
    assign bus.inst_valid    = head_valid;
    assign bus.inst_pc       = head_valid ? fifo_pc[rd_ptr]   : '0;
    assign bus.inst          = head_valid ? fifo_word[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            started     <= 1'b0;
            count       <= '0;
            outstanding <= '0;
            stale       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            tag_wr      <= '0;
            tag_rd      <= '0;
        end else begin
            started     <= 1'b1;
            outstanding <= out_next;
            if (req_fire)  tag_wr <= tag_wr + PW'(1);
            if (resp_take) tag_rd <= tag_rd + PW'(1);
            if (bus.redirect_valid) begin
                // Everything still in flight after this edge belongs to the old stream.
                fetch_pc <= bus.redirect_pc & 32'hFFFF_FFFC;
                count    <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                stale    <= out_next;
            end else begin
                if (req_fire)  fetch_pc <= fetch_pc + 32'd4;
                count <= count + CW'(push) - CW'(pop);
                if (push)      wr_ptr <= wr_ptr + PW'(1);
                if (pop)       rd_ptr <= rd_ptr + PW'(1);
                if (resp_drop) stale  <= stale - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) tag_pc[tag_wr] <= fetch_pc;
        if (push) begin
            fifo_pc[wr_ptr]   <= tag_pc[tag_rd];
            fifo_word[wr_ptr] <= bus.mem_resp_data;
        end
    end
endmodule

// File: tb/tb_ifu_prefetch.sv
// Bench for ifu_prefetch: cycle table for reset release plus directed
// backpressure, stall, redirect and wrap-around sequences with a scoreboard.
module tb_ifu_prefetch;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ifu_prefetch_if b ();
    ifu_prefetch_if w ();

    ifu_prefetch #(.DEPTH(4), .RESET_PC(32'h8000_0000)) dut (
        .clk(clk), .rst(rst), .bus(b)
    );
    ifu_prefetch #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .rst(rst), .bus(w)
    );

    typedef struct {
        logic        rdy;
        logic        irdy;
        logic        exp_rv;
        logic [31:0] exp_addr;
        logic        exp_iv;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t        tbl [8];
    int          vec_cnt = 0;
    int          err_cnt = 0;
    logic [31:0] mem_q [$];
    logic [31:0] exp_q [$];
    logic [31:0] w_q   [$];
    logic        resp_en;
    logic        s_rv, s_iv, acc;
    logic [31:0] s_addr, s_pc, s_inst;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One clock cycle: sample outputs mid-cycle, then drive inputs for the next edge.
    task automatic cyc(input logic rdy, input logic irdy, input logic redir, input logic [31:0] rpc);
        logic [31:0] a;
        @(negedge clk);
        s_rv   = b.mem_req_valid;
        s_addr = b.mem_req_addr;
        s_iv   = b.inst_valid;
        s_pc   = b.inst_pc;
        s_inst = b.inst;
        acc    = s_rv && rdy;
        b.mem_req_ready  = rdy;
        b.inst_ready     = irdy;
        b.redirect_valid = redir;
        b.redirect_pc    = rpc;
        if (resp_en && mem_q.size() > 0) begin
            a = mem_q.pop_front();
            b.mem_resp_valid = 1'b1;
            b.mem_resp_data  = word_of(a);
        end else begin
            b.mem_resp_valid = 1'b0;
            b.mem_resp_data  = '0;
        end
        if (s_iv && irdy) begin
            if (exp_q.size() == 0) begin
                vec_cnt++;
                err_cnt++;
                $display("FAIL sb_unexpected: got pc %h, expected no delivery", s_pc);
            end else begin
                a = exp_q.pop_front();
                chk("sb_pc", s_pc, a);
                chk("sb_inst", s_inst, word_of(a));
            end
        end
        if (acc) begin
            mem_q.push_back(s_addr);
            exp_q.push_back(s_addr);
        end
        if (redir) exp_q.delete();
        if (w.mem_req_valid) w_q.push_back(w.mem_req_addr);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_req_valid", 32'(b.mem_req_valid), 32'd0);
        chk("rst_req_addr", b.mem_req_addr, 32'h8000_0000);
        chk("rst_inst_valid", 32'(b.inst_valid), 32'd0);
        chk("rst_inst_pc", b.inst_pc, 32'd0);
        chk("rst_inst", b.inst, 32'd0);
        mem_q.delete();
        exp_q.delete();
        w_q.delete();
        b.mem_req_ready  = 1'b0;
        b.mem_resp_valid = 1'b0;
        b.mem_resp_data  = '0;
        b.inst_ready     = 1'b0;
        b.redirect_valid = 1'b0;
        b.redirect_pc    = '0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic drain(input int n);
        resp_en = 1'b1;
        repeat (n) cyc(1'b0, 1'b1, 1'b0, 32'd0);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int          n;
        logic [31:0] hold;
        tbl[0] = '{1'b1, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 32'h0};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 32'h8000_0000, 1'b0, 32'h0};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 32'h8000_0004, 1'b0, 32'h0};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 32'h8000_0008, 1'b1, 32'h8000_0000};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 32'h8000_000C, 1'b1, 32'h8000_0004};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 32'h8000_0010, 1'b1, 32'h8000_0008};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 32'h8000_0014, 1'b1, 32'h8000_000C};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 32'h8000_0018, 1'b1, 32'h8000_0010};

        w.mem_req_ready  = 1'b1;
        w.mem_resp_valid = 1'b0;
        w.mem_resp_data  = '0;
        w.inst_ready     = 1'b0;
        w.redirect_valid = 1'b0;
        w.redirect_pc    = '0;
        resp_en = 1'b1;

        // Reset release, sustained one-per-cycle fetch.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cyc(tbl[i].rdy, tbl[i].irdy, 1'b0, 32'd0);
            chk($sformatf("t%0d_req_valid", i), 32'(s_rv), 32'(tbl[i].exp_rv));
            chk($sformatf("t%0d_req_addr", i), s_addr, tbl[i].exp_addr);
            chk($sformatf("t%0d_inst_valid", i), 32'(s_iv), 32'(tbl[i].exp_iv));
            if (tbl[i].exp_iv) begin
                chk($sformatf("t%0d_inst_pc", i), s_pc, tbl[i].exp_pc);
                chk($sformatf("t%0d_inst", i), s_inst, word_of(tbl[i].exp_pc));
            end
        end
        chk("wrap_cnt", 32'(w_q.size()), 32'd4);
        chk("wrap_a0", w_q[0], 32'hFFFF_FFF8);
        chk("wrap_a1", w_q[1], 32'hFFFF_FFFC);
        chk("wrap_a2", w_q[2], 32'h0000_0000);
        drain(12);

        // Backpressure: credits stop at DEPTH, one consume frees one request.
        do_reset();
        n = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 32'd0);
            if (acc) n++;
        end
        chk("bp_accepts", 32'(n), 32'd4);
        chk("bp_req_low", 32'(s_rv), 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 32'd0);
        chk("bp_consume_valid", 32'(s_iv), 32'd1);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 32'd0);
            if (acc) n++;
        end
        chk("bp_one_more", 32'(n), 32'd1);
        chk("bp_req_low2", 32'(s_rv), 32'd0);

        // Memory stall: request held with a stable address.
        cyc(1'b0, 1'b1, 1'b0, 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 32'd0);
        hold = s_addr;
        chk("stall_addr0", hold, 32'h8000_0014);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 32'd0);
            chk($sformatf("stall%0d_valid", i), 32'(s_rv), 32'd1);
            chk($sformatf("stall%0d_addr", i), s_addr, hold);
        end
        drain(12);

        // Redirect with three requests in flight.
        do_reset();
        resp_en = 1'b0;
        repeat (4) cyc(1'b1, 1'b1, 1'b0, 32'd0);
        chk("redir_inflight", 32'(mem_q.size()), 32'd3);
        cyc(1'b0, 1'b1, 1'b1, 32'h0000_0103);
        resp_en = 1'b1;
        cyc(1'b1, 1'b1, 1'b0, 32'd0);
        chk("redir_addr", s_addr, 32'h0000_0100);
        chk("redir_iv_n1", 32'(s_iv), 32'd0);
        chk("redir_req_valid", 32'(s_rv), 32'd1);
        n = 0;
        while (!s_iv && n < 20) begin
            cyc(1'b1, 1'b1, 1'b0, 32'd0);
            n++;
        end
        chk("redir_first_valid", 32'(s_iv), 32'd1);
        chk("redir_first_pc", s_pc, 32'h0000_0100);
        drain(16);

        // Redirect coinciding with a response and a request accept.
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 32'd0);
        cyc(1'b1, 1'b0, 1'b1, 32'h0000_0200);
        chk("coll_accept", 32'(acc), 32'd1);
        chk("coll_resp", 32'(b.mem_resp_valid), 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 32'd0);
        chk("coll_iv_n1", 32'(s_iv), 32'd0);
        chk("coll_addr", s_addr, 32'h0000_0200);
        cyc(1'b1, 1'b0, 1'b0, 32'd0);
        chk("coll_iv_n2", 32'(s_iv), 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 32'd0);
        chk("coll_iv_n3", 32'(s_iv), 32'd1);
        chk("coll_pc_n3", s_pc, 32'h0000_0200);

        // Mid-operation reset aborts immediately (checked inside do_reset).
        do_reset();
        cyc(1'b0, 1'b0, 1'b0, 32'd0);
        chk("post_rst_iv", 32'(s_iv), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
